// File: rtl/imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imem_loader
// Purpose  : Assembles a little-endian byte stream into words, writes them to
//            imem, zero-fills the remainder and holds the core in reset until
//            the image is complete. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module imem_loader #(
  parameter int N      = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [N-1:0]      wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_reset
);

  localparam int NB = N / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = ADDR_W + 1;
  localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
  localparam logic [BW-1:0] LAST_B  = BW'(NB - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FILL  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd7;
`endif

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [N-1:0]      word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic              byte_ready_q, byte_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_reset_q, cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept;
  logic [IW-1:0]     idx_inc;
  logic              go_fill;
  logic [IW-1:0]     fill_addr;

  assign accept  = byte_valid & byte_ready_q;
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    go_fill   = 1'b0;
    fill_addr = idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_COUNT;
          idx_d   = '0;
          bidx_d  = '0;
          word_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_COUNT: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = byte_in;
`endif
          // Compare at full byte width so oversize counts never alias
          if (32'(byte_in) > 32'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            cnt_d = IW'(byte_in);
            if (byte_in == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              go_fill   = 1'b1;
              fill_addr = '0;
`endif
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_in;
`endif
          word_d[8*bidx_q +: 8] = byte_in;
          if (bidx_q == LAST_B) begin
            state_d = S_WRITE;
            bidx_d  = '0;
            waddr_d = idx_q[ADDR_W-1:0];
            wdata_d = word_d;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          go_fill   = 1'b1;
          fill_addr = idx_inc;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (byte_in == csum_q) begin
            go_fill   = 1'b1;
            fill_addr = idx_q;
          end else begin
            state_d = S_ERR;
          end
        end
      end
`endif
      S_FILL: begin
        go_fill   = 1'b1;
        fill_addr = idx_inc;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared entry into FILL: a start address of DEPTH means nothing left to fill
    if (go_fill) begin
      idx_d = fill_addr;
      if (fill_addr == DEPTH_I) begin
        state_d = S_DONE;
      end else begin
        state_d = S_FILL;
        waddr_d = fill_addr[ADDR_W-1:0];
        wdata_d = '0;
      end
    end

    we_d         = (state_d == S_WRITE) || (state_d == S_FILL);
    byte_ready_d = (state_d == S_COUNT) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_ready_d = byte_ready_d || (state_d == S_CHECK);
`endif
    busy_d      = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    cpu_reset_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_reset_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cpu_reset_q  <= cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_reset  = cpu_reset_q;

endmodule
`default_nettype wire
